// File: rtl/amm_dma_pkg.sv
// Shared constants and types for the Avalon-MM DMA engine: CSR map, bit positions,
// transfer modes and master FSM states.
package amm_dma_pkg;

  localparam int unsigned CsrCtrl   = 0;
  localparam int unsigned CsrStatus = 1;
  localparam int unsigned CsrSrc    = 2;
  localparam int unsigned CsrDst    = 3;
  localparam int unsigned CsrLen    = 4;
  localparam int unsigned CsrFill   = 5;
  localparam int unsigned CsrCount  = 6;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlAbort   = 1;
  localparam int unsigned CtrlModeLsb = 2;
  localparam int unsigned CtrlIrqEn   = 4;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatAborted = 2;

  typedef enum logic [1:0] {
    ModeCopy = 2'd0,
    ModeFill = 2'd1,
    ModeIncr = 2'd2,
    ModeRsvd = 2'd3
  } dma_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StFinish
  } dma_state_e;

endpackage

// File: rtl/amm_dma_csr.sv
// CSR slave for the DMA engine: register file, one-cycle registered read path and
// start/abort command pulses.
module amm_dma_csr
  import amm_dma_pkg::*;
#(
  parameter int unsigned MASTER_ADDRESSWIDTH = 26,
  parameter int unsigned SLAVE_ADDRESSWIDTH  = 3,
  parameter int unsigned DATAWIDTH           = 32,
  parameter int unsigned LENWIDTH            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  input  logic                           busy,
  input  logic                           done,
  input  logic                           aborted,
  input  logic [LENWIDTH-1:0]            count,
  output logic [MASTER_ADDRESSWIDTH-1:0] src,
  output logic [MASTER_ADDRESSWIDTH-1:0] dst,
  output logic [LENWIDTH-1:0]            len,
  output logic [DATAWIDTH-1:0]           fill,
  output dma_mode_e                      mode,
  output logic                           irq_en,
  output logic                           start,
  output logic                           abort,
  output logic                           done_clr,
  output logic                           aborted_clr
);

  logic                 wr, rd;
  logic [31:0]          addr;
  logic [DATAWIDTH-1:0] rdata;

  assign wr   = slave_chipselect && slave_write;
  assign rd   = slave_chipselect && slave_read;
  assign addr = 32'(slave_address);

  assign done_clr    = wr && addr == CsrStatus && slave_writedata[StatDone];
  assign aborted_clr = wr && addr == CsrStatus && slave_writedata[StatAborted];

  always_comb begin
    rdata = '0;
    case (addr)
      CsrCtrl: begin
        rdata[CtrlIrqEn]          = irq_en;
        rdata[CtrlModeLsb +: 2]   = mode;
      end
      CsrStatus: begin
        rdata[StatBusy]    = busy;
        rdata[StatDone]    = done;
        rdata[StatAborted] = aborted;
      end
      CsrSrc:   rdata = DATAWIDTH'(src);
      CsrDst:   rdata = DATAWIDTH'(dst);
      CsrLen:   rdata = DATAWIDTH'(len);
      CsrFill:  rdata = fill;
      CsrCount: rdata = DATAWIDTH'(count);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src            <= '0;
      dst            <= '0;
      len            <= '0;
      fill           <= '0;
      mode           <= ModeCopy;
      irq_en         <= 1'b0;
      start          <= 1'b0;
      abort          <= 1'b0;
      slave_readdata <= '0;
    end else begin
      // Abort wins over a start carried in the same CTRL write.
      start <= wr && addr == CsrCtrl && slave_writedata[CtrlStart] &&
               !slave_writedata[CtrlAbort] && !busy;
      abort <= wr && addr == CsrCtrl && slave_writedata[CtrlAbort];
      if (wr && addr == CsrCtrl) begin
        irq_en <= slave_writedata[CtrlIrqEn];
        if (!busy) mode <= dma_mode_e'(slave_writedata[CtrlModeLsb +: 2]);
      end
      if (wr && !busy) begin
        if (addr == CsrSrc)  src  <= MASTER_ADDRESSWIDTH'(slave_writedata);
        if (addr == CsrDst)  dst  <= MASTER_ADDRESSWIDTH'(slave_writedata);
        if (addr == CsrLen)  len  <= LENWIDTH'(slave_writedata);
        if (addr == CsrFill) fill <= slave_writedata;
      end
      if (rd) slave_readdata <= rdata;
    end
  end

endmodule

// File: rtl/amm_dma_engine.sv
// Avalon-MM DMA engine: copy, fill or incrementing-fill of LEN words from a CSR-programmed
// source/destination, one outstanding master request at a time.
module amm_dma_engine
  import amm_dma_pkg::*;
#(
  parameter int unsigned MASTER_ADDRESSWIDTH = 26,
  parameter int unsigned SLAVE_ADDRESSWIDTH  = 3,
  parameter int unsigned DATAWIDTH           = 32,
  parameter int unsigned LENWIDTH            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           irq
);

  localparam logic [MASTER_ADDRESSWIDTH-1:0] AddrStep = MASTER_ADDRESSWIDTH'(DATAWIDTH / 8);

  dma_state_e                     state_q;
  logic                           busy_q, done_q, aborted_q, abort_pend_q;
  logic [LENWIDTH-1:0]            count_q, count_inc;
  logic [MASTER_ADDRESSWIDTH-1:0] src_q, dst_q;
  logic [DATAWIDTH-1:0]           data_q, wdata;

  logic [MASTER_ADDRESSWIDTH-1:0] cfg_src, cfg_dst;
  logic [LENWIDTH-1:0]            cfg_len;
  logic [DATAWIDTH-1:0]           cfg_fill;
  dma_mode_e                      cfg_mode;
  logic                           irq_en, start, abort, done_clr, aborted_clr;
  logic                           is_copy, abort_seen;

  amm_dma_csr #(
    .MASTER_ADDRESSWIDTH(MASTER_ADDRESSWIDTH),
    .SLAVE_ADDRESSWIDTH (SLAVE_ADDRESSWIDTH),
    .DATAWIDTH          (DATAWIDTH),
    .LENWIDTH           (LENWIDTH)
  ) u_csr (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .slave_write      (slave_write),
    .slave_read       (slave_read),
    .slave_chipselect (slave_chipselect),
    .slave_readdata   (slave_readdata),
    .busy             (busy_q),
    .done             (done_q),
    .aborted          (aborted_q),
    .count            (count_q),
    .src              (cfg_src),
    .dst              (cfg_dst),
    .len              (cfg_len),
    .fill             (cfg_fill),
    .mode             (cfg_mode),
    .irq_en           (irq_en),
    .start            (start),
    .abort            (abort),
    .done_clr         (done_clr),
    .aborted_clr      (aborted_clr)
  );

  assign is_copy    = !(cfg_mode == ModeFill || cfg_mode == ModeIncr);
  assign abort_seen = abort_pend_q || (abort && busy_q);
  assign count_inc  = count_q + LENWIDTH'(1);
  assign irq        = done_q && irq_en;

  always_comb begin
    wdata = data_q;
    case (cfg_mode)
      ModeFill: wdata = cfg_fill;
      ModeIncr: wdata = cfg_fill + DATAWIDTH'(count_q);
      default:  wdata = data_q;
    endcase
  end

  // Master outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    if (state_q == StRdReq) begin
      master_read    = 1'b1;
      master_address = src_q;
    end else if (state_q == StWrReq) begin
      master_write     = 1'b1;
      master_address   = dst_q;
      master_writedata = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      count_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
    end else begin
      if (done_clr)         done_q       <= 1'b0;
      if (aborted_clr)      aborted_q    <= 1'b0;
      if (abort && busy_q)  abort_pend_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= '0;
            src_q   <= cfg_src;
            dst_q   <= cfg_dst;
            if (cfg_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= is_copy ? StRdReq : StWrReq;
            end
          end
        end
        StRdReq: if (!master_waitrequest) state_q <= StRdWait;
        StRdWait: begin
          if (master_readdatavalid) begin
            data_q  <= master_readdata;
            state_q <= StWrReq;
          end
        end
        StWrReq: begin
          if (!master_waitrequest) begin
            count_q <= count_inc;
            src_q   <= src_q + AddrStep;
            dst_q   <= dst_q + AddrStep;
            // A pending abort only takes effect once the in-flight word has been written.
            if (count_inc == cfg_len || abort_seen) state_q <= StFinish;
            else                                    state_q <= is_copy ? StRdReq : StWrReq;
          end
        end
        StFinish: begin
          busy_q       <= 1'b0;
          abort_pend_q <= 1'b0;
          if (abort_seen) aborted_q <= 1'b1;
          else            done_q    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
